// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//   Shares one memory/peripheral slave between N_MASTERS bus masters using the
//   core bus handshake (address, wdata, wmask, level-held wen/ren, single-cycle
//   done). Arbitration is round-robin, and the grant is held for one whole
//   transaction.
//
//   Optional feature macro: BUS_ARB_TIMEOUT_EN
//     When defined, a watchdog ends a transaction that has waited
//     TIMEOUT_CYCLES cycles in GRANT without s_done. The master gets a
//     completion pulse with read data 32'hDEAD_BEEF, and the timeout_err port
//     pulses for the same cycle.
//     When undefined, there is no counter and no timeout_err port.
//
// Parameters
//   N_MASTERS       number of masters, 2..8
//   TIMEOUT_CYCLES  watchdog limit in cycles (used only with BUS_ARB_TIMEOUT_EN)
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   m_addr/m_wdata  per-master address/write data, master i at [32*i +: 32]
//   m_wmask         per-master byte mask, master i at [4*i +: 4]
//   m_wen/m_ren     per-master level-held write/read requests
//   m_rdata         read data broadcast to all masters
//   m_done          per-master one-cycle completion pulse
//   s_*             slave side; s_* outputs are combinational from the grant
//   grant           one-hot registered owner, 0 when idle
//   busy            transaction in flight
//   timeout_err     watchdog expiry pulse (BUS_ARB_TIMEOUT_EN only)
// -----------------------------------------------------------------------------
module bus_arbiter #(
  parameter int N_MASTERS      = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_MASTERS*32-1:0] m_addr,
  input  logic [N_MASTERS*32-1:0] m_wdata,
  input  logic [N_MASTERS*4-1:0]  m_wmask,
  input  logic [N_MASTERS-1:0]    m_wen,
  input  logic [N_MASTERS-1:0]    m_ren,
  output logic [31:0]             m_rdata,
  output logic [N_MASTERS-1:0]    m_done,
  output logic [31:0]             s_addr,
  output logic [31:0]             s_wdata,
  output logic [3:0]              s_wmask,
  output logic                    s_wen,
  output logic                    s_ren,
  input  logic [31:0]             s_rdata,
  input  logic                    s_done,
  output logic [N_MASTERS-1:0]    grant,
`ifdef BUS_ARB_TIMEOUT_EN
  output logic                    timeout_err,
`endif
  output logic                    busy
);

  localparam int IW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  if (N_MASTERS < 2 || N_MASTERS > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("bus_arbiter: N_MASTERS must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  logic [0:0]           r_state;
  logic [N_MASTERS-1:0] r_grant;
  logic [IW-1:0]        r_gidx;
  logic [IW-1:0]        r_rr_ptr;

  logic [N_MASTERS-1:0] w_req;
  logic                 w_any;
  logic [IW-1:0]        w_pick;
  logic [N_MASTERS-1:0] w_pick_oh;
  logic                 w_owner_req;
  logic                 w_timeout;
  logic                 w_release;
  logic [IW-1:0]        w_rr_next;

  assign w_req = m_wen | m_ren;
  assign w_any = |w_req;

  // Cyclic search starting at r_rr_ptr. The loop runs from the farthest offset
  // down to 0 so the requester closest to the pointer is the last one written.
  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_pick = r_rr_ptr;
    for (int off = N_MASTERS - 1; off >= 0; off--) begin
      if (w_req[(int'(r_rr_ptr) + off) % N_MASTERS]) begin
        w_pick = IW'((int'(r_rr_ptr) + off) % N_MASTERS);
      end
    end
  end

  always_comb begin
    w_pick_oh = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      w_pick_oh[i] = (w_pick == IW'(i));
    end
  end

  // Slave-side mux. r_grant is zero in IDLE, so every s_* output is zero there
  // without an extra state qualifier. Write wins if a master holds both strobes.
  always_comb begin
    s_addr      = '0;
    s_wdata     = '0;
    s_wmask     = '0;
    s_wen       = 1'b0;
    s_ren       = 1'b0;
    w_owner_req = 1'b0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (r_grant[i]) begin
        s_addr      = m_addr[32*i +: 32];
        s_wdata     = m_wdata[32*i +: 32];
        s_wmask     = m_wmask[4*i +: 4];
        s_wen       = m_wen[i];
        s_ren       = m_ren[i] & ~m_wen[i];
        w_owner_req = w_req[i];
      end
    end
  end

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_cnt;

  // The counter holds the number of GRANT cycles already spent, so it equals
  // TIMEOUT_CYCLES during the cycle that lies TIMEOUT_CYCLES after the grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_state == ST_IDLE) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // A real s_done in the expiry cycle is a normal completion.
  assign w_timeout   = (r_state == ST_GRANT) && (r_cnt == CW'(TIMEOUT_CYCLES)) && !s_done;
  assign timeout_err = w_timeout;
  assign m_rdata     = w_timeout ? 32'hDEAD_BEEF : s_rdata;
`else
  assign w_timeout = 1'b0;
  assign m_rdata   = s_rdata;
`endif

  // s_done in IDLE cannot reach m_done because r_grant is zero there.
  assign m_done = r_grant & {N_MASTERS{s_done | w_timeout}};

  // Completion, abandon (owner dropped both strobes) or watchdog expiry.
  assign w_release = s_done | ~w_owner_req | w_timeout;
  assign w_rr_next = (r_gidx == IW'(N_MASTERS - 1)) ? '0 : r_gidx + IW'(1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the clock edge, whatever the statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
      r_gidx   <= '0;
      r_rr_ptr <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state <= ST_GRANT;
            r_grant <= w_pick_oh;
            r_gidx  <= w_pick;
          end
        end
        ST_GRANT: begin
          if (w_release) begin
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_rr_ptr <= w_rr_next;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

  assign grant = r_grant;
  assign busy  = (r_state == ST_GRANT);

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
//   Directed bench for bus_arbiter with two masters. A behavioural model tracks
//   the current owner and the round-robin pointer as plain integers, and the
//   compare process checks every DUT output against it on each falling edge.
//   Hand-computed literal checks pin the key cycles of each scenario.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

  localparam int N     = 2;
  localparam int TB_TO = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [N*32-1:0]   m_addr  = '0;
  logic [N*32-1:0]   m_wdata = '0;
  logic [N*4-1:0]    m_wmask = '0;
  logic [N-1:0]      m_wen   = '0;
  logic [N-1:0]      m_ren   = '0;
  logic [31:0]       s_rdata = '0;
  logic              s_done  = 1'b0;
  logic [31:0]       m_rdata;
  logic [N-1:0]      m_done;
  logic [31:0]       s_addr;
  logic [31:0]       s_wdata;
  logic [3:0]        s_wmask;
  logic              s_wen;
  logic              s_ren;
  logic [N-1:0]      grant;
  logic              busy;
`ifdef BUS_ARB_TIMEOUT_EN
  logic              timeout_err;
`endif

  int n_vec = 0;
  int n_err = 0;

  bus_arbiter #(.N_MASTERS(N), .TIMEOUT_CYCLES(TB_TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .m_addr     (m_addr),
    .m_wdata    (m_wdata),
    .m_wmask    (m_wmask),
    .m_wen      (m_wen),
    .m_ren      (m_ren),
    .m_rdata    (m_rdata),
    .m_done     (m_done),
    .s_addr     (s_addr),
    .s_wdata    (s_wdata),
    .s_wmask    (s_wmask),
    .s_wen      (s_wen),
    .s_ren      (s_ren),
    .s_rdata    (s_rdata),
    .s_done     (s_done),
    .grant      (grant),
`ifdef BUS_ARB_TIMEOUT_EN
    .timeout_err(timeout_err),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: owner index (-1 when idle), round-robin pointer and the
  // number of cycles the owner has held the bus.
  // ---------------------------------------------------------------------------
  int own = -1;
  int rr  = 0;
  int cnt = 0;

  function automatic int pick(input int start, input logic [N-1:0] req);
    int r = -1;
    for (int off = 0; off < N; off++) begin
      if (r < 0 && req[(start + off) % N]) r = (start + off) % N;
    end
    return r;
  endfunction

  function automatic bit expired(input int c);
`ifdef BUS_ARB_TIMEOUT_EN
    return (c == TB_TO);
`else
    return (c < 0);
`endif
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      own <= -1;
      rr  <= 0;
      cnt <= 0;
    end else if (own < 0) begin
      own <= pick(rr, m_wen | m_ren);
      cnt <= 0;
    end else if (s_done || !(m_wen[own] || m_ren[own]) || expired(cnt)) begin
      rr  <= (own + 1) % N;
      own <= -1;
    end else begin
      cnt <= cnt + 1;
    end
  end

  // Compare process: every output, every cycle.
  always @(negedge clk) begin
    logic [31:0] e_addr, e_wdata, e_rdata;
    logic [3:0]  e_mask;
    logic        e_wen, e_ren, e_to;
    logic [N-1:0] e_grant, e_done;
    e_addr = '0; e_wdata = '0; e_mask = '0; e_wen = 1'b0; e_ren = 1'b0;
    e_grant = '0; e_done = '0; e_to = 1'b0;
    if (own >= 0) begin
      e_addr  = m_addr[32*own +: 32];
      e_wdata = m_wdata[32*own +: 32];
      e_mask  = m_wmask[4*own +: 4];
      e_wen   = m_wen[own];
      e_ren   = m_ren[own] && !m_wen[own];
      e_grant = N'(1) << own;
      e_to    = expired(cnt) && !s_done;
      if (s_done || e_to) e_done = e_grant;
    end
    e_rdata = e_to ? 32'hDEAD_BEEF : s_rdata;
    check("model.grant",   32'(grant),   32'(e_grant));
    check("model.busy",    32'(busy),    32'(own >= 0));
    check("model.s_addr",  s_addr,       e_addr);
    check("model.s_wdata", s_wdata,      e_wdata);
    check("model.s_wmask", 32'(s_wmask), 32'(e_mask));
    check("model.s_wen",   32'(s_wen),   32'(e_wen));
    check("model.s_ren",   32'(s_ren),   32'(e_ren));
    check("model.m_done",  32'(m_done),  32'(e_done));
    check("model.m_rdata", m_rdata,      e_rdata);
`ifdef BUS_ARB_TIMEOUT_EN
    check("model.timeout_err", 32'(timeout_err), 32'(e_to));
`endif
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic set_master(input int i, input logic wen, input logic ren,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] mask);
    m_wen[i]            = wen;
    m_ren[i]            = ren;
    m_addr[32*i +: 32]  = addr;
    m_wdata[32*i +: 32] = wdata;
    m_wmask[4*i +: 4]   = mask;
  endtask

  initial begin
    // Reset
    #1 rst = 1'b1;
    #1;
    check("reset.grant", 32'(grant), 32'h0);
    check("reset.busy",  32'(busy),  32'h0);
    at_neg(); at_neg();
    rst = 1'b0;

    // Contention with rr_ptr = 0: m0 first, then m1
    tick();
    set_master(0, 1'b0, 1'b1, 32'h0000_0010, 32'h0, 4'h0);
    set_master(1, 1'b0, 1'b1, 32'h0000_0020, 32'h0, 4'h0);
    at_neg(); check("cont1.idle_grant", 32'(grant), 32'h0);
    tick();   at_neg(); check("cont1.first_grant", 32'(grant), 32'h1);
    check("cont1.first_addr", s_addr, 32'h0000_0010);
    tick(); s_done = 1'b1; s_rdata = 32'h0000_00A0;
    at_neg(); check("cont1.first_done", 32'(m_done), 32'h1);
    tick(); s_done = 1'b0; m_ren[0] = 1'b0;
    at_neg(); check("cont1.between_idle", 32'(busy), 32'h0);
    tick();   at_neg(); check("cont1.second_grant", 32'(grant), 32'h2);
    tick(); s_done = 1'b1; s_rdata = 32'h0000_00B0;
    at_neg(); check("cont1.second_done", 32'(m_done), 32'h2);
    tick(); s_done = 1'b0; m_ren[1] = 1'b0;

    // Single read by m0: grant one cycle after request, done in cycle 3
    set_master(0, 1'b0, 1'b1, 32'h0000_0100, 32'h0, 4'h0);
    at_neg(); check("single.c0_grant", 32'(grant), 32'h0);
    tick();   at_neg(); check("single.c1_grant", 32'(grant), 32'h1);
    check("single.c1_ren", 32'(s_ren), 32'h1);
    tick();
    tick(); s_done = 1'b1; s_rdata = 32'h1234_5678;
    at_neg(); check("single.c3_done", 32'(m_done), 32'h1);
    check("single.c3_rdata", m_rdata, 32'h1234_5678);
    tick(); s_done = 1'b0; m_ren[0] = 1'b0;
    at_neg(); check("single.c4_busy", 32'(busy), 32'h0);

    // Contention again, now rr_ptr = 1: m1 first
    set_master(0, 1'b0, 1'b1, 32'h0000_0030, 32'h0, 4'h0);
    set_master(1, 1'b0, 1'b1, 32'h0000_0040, 32'h0, 4'h0);
    tick();   at_neg(); check("cont2.first_grant", 32'(grant), 32'h2);
    tick(); s_done = 1'b1; s_rdata = 32'h0000_00C0;
    tick(); s_done = 1'b0; m_ren[1] = 1'b0;
    tick();   at_neg(); check("cont2.second_grant", 32'(grant), 32'h1);
    tick(); s_done = 1'b1;
    tick(); s_done = 1'b0; m_ren[0] = 1'b0;

    // Write passthrough from m1 (ren also held: write must win)
    set_master(1, 1'b1, 1'b1, 32'h0000_0204, 32'hAABB_CCDD, 4'b1100);
    tick();   at_neg(); check("write.grant", 32'(grant), 32'h2);
    check("write.s_addr",  s_addr,       32'h0000_0204);
    check("write.s_wdata", s_wdata,      32'hAABB_CCDD);
    check("write.s_wmask", 32'(s_wmask), 32'hC);
    check("write.s_wen",   32'(s_wen),   32'h1);
    check("write.s_ren",   32'(s_ren),   32'h0);
    tick();   at_neg(); check("write.m0_done_quiet", 32'(m_done[0]), 32'h0);
    tick(); s_done = 1'b1;
    at_neg(); check("write.done", 32'(m_done), 32'h2);
    tick(); s_done = 1'b0; set_master(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    // Abandon: m0 granted, drops ren two cycles into GRANT; m1 pending
    set_master(0, 1'b0, 1'b1, 32'h0000_0300, 32'h0, 4'h0);
    set_master(1, 1'b0, 1'b1, 32'h0000_0304, 32'h0, 4'h0);
    tick();   at_neg(); check("abandon.grant_m0", 32'(grant), 32'h1);
    tick();
    tick(); m_ren[0] = 1'b0;
    at_neg(); check("abandon.no_done", 32'(m_done), 32'h0);
    tick();   at_neg(); check("abandon.idle", 32'(grant), 32'h0);
    tick();   at_neg(); check("abandon.grant_m1", 32'(grant), 32'h2);
    tick(); s_done = 1'b1; s_rdata = 32'h5555_AAAA;
    at_neg(); check("abandon.m1_done", 32'(m_done), 32'h2);
    tick(); s_done = 1'b0; m_ren[1] = 1'b0;

    // Reset mid-transaction
    set_master(0, 1'b0, 1'b1, 32'h0000_0400, 32'h0, 4'h0);
    tick();   at_neg(); check("rstmid.grant", 32'(grant), 32'h1);
    tick();
    #2 rst = 1'b1;
    #1;
    check("rstmid.grant_cleared", 32'(grant),  32'h0);
    check("rstmid.busy_cleared",  32'(busy),   32'h0);
    check("rstmid.s_ren_cleared", 32'(s_ren),  32'h0);
    check("rstmid.s_addr_cleared", s_addr,     32'h0);
    m_ren[0] = 1'b0;
    at_neg(); rst = 1'b0;
    tick(); set_master(1, 1'b0, 1'b1, 32'h0000_0500, 32'h0, 4'h0);
    tick();   at_neg(); check("rstmid.m1_grant", 32'(grant), 32'h2);
    tick(); s_done = 1'b1; s_rdata = 32'h0BAD_F00D;
    at_neg(); check("rstmid.m1_done", 32'(m_done), 32'h2);
    check("rstmid.m1_rdata", m_rdata, 32'h0BAD_F00D);
    tick(); s_done = 1'b0; m_ren[1] = 1'b0;

    // s_done while idle is ignored
    s_done = 1'b1;
    at_neg(); check("idle_done.ignored", 32'(m_done), 32'h0);
    tick(); s_done = 1'b0;

`ifdef BUS_ARB_TIMEOUT_EN
    // Watchdog: slave never answers
    set_master(0, 1'b0, 1'b1, 32'h0000_0600, 32'h0, 4'h0);
    tick();   at_neg(); check("to.grant", 32'(grant), 32'h1);
    check("to.early_err", 32'(timeout_err), 32'h0);
    repeat (TB_TO) tick();
    at_neg(); check("to.done", 32'(m_done), 32'h1);
    check("to.err",   32'(timeout_err), 32'h1);
    check("to.rdata", m_rdata, 32'hDEAD_BEEF);
    tick(); m_ren[0] = 1'b0;
    at_neg(); check("to.idle", 32'(busy), 32'h0);
`endif

    tick(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
